// File: rtl/serial_frame_tx.sv
// serial_frame_tx
// Framed parallel-to-serial transmitter for the team's shift-register link.
// A WIDTH-bit word accepted over valid/ready is sent as: start bit (0),
// data bits (LSB- or MSB-first), optional even-parity bit, stop bit (1).
// Every bit is held on the line for DIV clock cycles; the line idles high.
// Optional feature macro: SERIAL_TX_PARITY_EN inserts the even-parity bit
// between the last data bit and the stop bit.
module serial_frame_tx #(
   parameter int WIDTH = 4,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             msb_first,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   // The divide counter needs at least one bit even when DIV is 1.
   localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BITW = $clog2(WIDTH + 1);

   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);
   localparam logic [DIVW-1:0] DIV_ONE  = DIVW'(1);
   localparam logic [BITW-1:0] BIT_LAST = BITW'(WIDTH - 1);
   localparam logic [BITW-1:0] BIT_ONE  = BITW'(1);

`ifdef SERIAL_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } txState_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3
   } txState_t;
`endif

   txState_t         r_state;
   txState_t         w_nextState;
   logic [WIDTH-1:0] r_shift;
   logic             r_msbFirst;
   logic [BITW-1:0]  r_bitCount;
   logic [DIVW-1:0]  r_divCount;
   logic             r_done;
`ifdef SERIAL_TX_PARITY_EN
   logic             r_parity;
`endif
   logic             w_bitEnd;
   logic             w_lastBit;

   // A bit period ends on the last cycle of the divide count; the data
   // phase ends when that happens on the final data bit.
   assign w_bitEnd  = (r_divCount == DIV_LAST);
   assign w_lastBit = (r_bitCount == BIT_LAST);
   assign done      = r_done;

   // State register; reset forces the line back to idle and drops any frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and output decode; outputs depend only on registered state,
   // so in_valid never reaches an output combinationally.
   always_comb begin
      w_nextState = r_state;
      serial_out  = 1'b1;
      in_ready    = 1'b0;
      busy        = 1'b1;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               w_nextState = START;
            end
         end
         START: begin
            serial_out = 1'b0;
            if (w_bitEnd) begin
               w_nextState = DATA;
            end
         end
         DATA: begin
            serial_out = r_msbFirst ? r_shift[WIDTH-1] : r_shift[0];
            if (w_bitEnd && w_lastBit) begin
`ifdef SERIAL_TX_PARITY_EN
               w_nextState = PARITY;
`else
               w_nextState = STOP;
`endif
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            serial_out = r_parity;
            if (w_bitEnd) begin
               w_nextState = STOP;
            end
         end
`endif
         STOP: begin
            serial_out = 1'b1;
            if (w_bitEnd) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Datapath: capture the word and bit order at accept, pace bit periods
   // with the divide counter, shift toward the output bit after each data
   // bit, and flag done on the cycle the stop bit finishes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift    <= '0;
         r_msbFirst <= 1'b0;
         r_bitCount <= '0;
         r_divCount <= '0;
         r_done     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         r_done <= (r_state == STOP) && w_bitEnd;
         if (r_state == IDLE) begin
            r_divCount <= '0;
            r_bitCount <= '0;
            if (in_valid) begin
               r_shift    <= in_data;
               r_msbFirst <= msb_first;
`ifdef SERIAL_TX_PARITY_EN
               r_parity   <= ^in_data;
`endif
            end
         end else begin
            r_divCount <= w_bitEnd ? '0 : (r_divCount + DIV_ONE);
            if ((r_state == DATA) && w_bitEnd) begin
               r_shift    <= r_msbFirst ? (r_shift << 1) : (r_shift >> 1);
               r_bitCount <= r_bitCount + BIT_ONE;
            end
         end
      end
   end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Parallel-to-serial frame transmitter: the transmit end of the team's serial shift-register link. It accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a single line as a framed bit stream: start bit, data bits LSB- or MSB-first, optional parity bit, stop bit. Each bit is held for DIV clock cycles. It feeds the link that the team's shift-register receiver samples.

## Interface
- WIDTH, default 4: data word width in bits; legal range 1 or more.
- DIV, default 1: clock cycles per bit period; legal range 1 or more.
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- in_data  input  WIDTH  word to transmit.
- msb_first  input  1  bit order: 1 = MSB first, 0 = LSB first; sampled at accept.
- serial_out  output  1  serial line; idles high.
- busy  output  1  a frame is in progress (any state other than IDLE).
- done  output  1  one-cycle pulse on the first IDLE cycle after a stop bit.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only when the parity macro is defined), STOP.
- IDLE:
  - serial_out=1, in_ready=1, busy=0.
  - An accept happens when in_valid&&in_ready is seen at a rising edge. On accept, latch in_data into the shift register, latch msb_first, clear the bit counter and the divide counter, and go to START.
- START: serial_out=0 for DIV cycles, then go to DATA.
- DATA:
  - serial_out is the current output bit of the shift register: bit 0 when LSB-first, bit WIDTH-1 when MSB-first.
  - At the end of each bit period, shift the register toward the output bit and increment the bit counter.
  - After WIDTH bit periods, go to PARITY if the macro is defined, else STOP.
- PARITY: serial_out = XOR of the latched word (even parity) for DIV cycles, then go to STOP.
- STOP: serial_out=1 for DIV cycles, then go to IDLE and assert done for that first IDLE cycle.
- Counter widths:
  - Divide counter: $clog2(DIV) bits, minimum 1. It counts 0..DIV-1; the bit period ends when it equals DIV-1.
  - Bit counter: $clog2(WIDTH+1) bits.
  - Neither counter may wrap inside a frame.
- Simultaneous events:
  - in_valid while busy is ignored. No word is captured, and in_data may change freely.
  - On the done cycle in_ready=1, so a new word can be accepted in that same cycle.
- Reset:
  - Reset has priority over every other event.
  - Reset mid-frame abandons the frame. On the next cycle the block is in IDLE with serial_out=1, in_ready=1, busy=0, done=0, and no partial frame resumes.

## Timing
- Reset values: serial_out=1, in_ready=1, busy=0, done=0, state IDLE, shift register and counters all 0.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid to any output.
- Latency:
  - Accept at edge N; the start bit appears on serial_out from cycle N+1.
  - Frame length is (WIDTH+2)*DIV cycles, or (WIDTH+3)*DIV cycles with parity.
  - done pulses at cycle N+1+frame_length.
- Back-to-back frames: one idle-high cycle between the stop bit and the next start bit (the done/accept cycle).
- The line sequence for a word depends only on values latched at accept.

## Configuration
- Macro: SERIAL_TX_PARITY_EN.
- Defined: the PARITY state is present, an even-parity bit is inserted between the last data bit and STOP, and the frame is WIDTH+3 bit periods long.
- Undefined: the PARITY state and parity logic are absent, and the frame is WIDTH+2 bit periods long.

## Test plan
- WIDTH=4, DIV=1, no parity: accept 4'b1011 with msb_first=0 -> serial_out 0,1,1,0,1,1 over 6 cycles, then done=1 for 1 cycle and serial_out=1.
- Same word with msb_first=1 -> serial_out 0,1,0,1,1,1.
- SERIAL_TX_PARITY_EN defined: 4'b1011 LSB-first -> 0,1,1,0,1,1(parity),1(stop), 7 cycles. Then 4'b0011 -> parity bit 0.
- DIV=3: 4'b0001 LSB-first -> each bit held 3 cycles, 18 cycles total. in_ready=0 and busy=1 for all 18 cycles, and an in_valid pulse mid-frame is not captured.
- Back-to-back: in_valid held high with words 4'hA then 4'h5 -> second start bit follows the first stop bit after exactly one serial_out=1 cycle, and done pulses twice.
- Reset asserted during the DATA state of 4'hF -> next cycle serial_out=1, in_ready=1, busy=0, done=0. A fresh accept of 4'h0 then produces the complete frame 0,0,0,0,0,1.
